// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and mem-side signals around mem_arbiter.
// The arbiter uses the slave modport; requesters and the mem model use master.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [7:0]  dma_rdata;

    logic [15:0] mem_addr;
    logic        mem_rw_sel;
    logic [7:0]  mem_wdata;
    logic        mem_wdata_oe;
    logic [7:0]  mem_rdata;
    logic        wr_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        output dma_gnt, dma_done, dma_rdata,
        output mem_addr, mem_rw_sel, mem_wdata, mem_wdata_oe, wr_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_addr, mem_rw_sel, mem_wdata, mem_wdata_oe, wr_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single-port mem block: CPU priority, DMA anti-starvation counter.
// Define MEM_ARB_ROM_PROTECT_EN to turn writes at or above ROM_BASE into dummy reads with wr_err.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [15:0] ROM_BASE = 16'hC000
) (
    input logic          ph2_i,
    input logic          reset_i,
    mem_arbiter_if.slave bus_io
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam bit RomProtect = 1'b1;
`else
    localparam bit RomProtect = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;  // 1 = DMA owns the current access
    logic        we_q, we_d;
    logic        blk_q, blk_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_rw_sel_q, mem_rw_sel_d;
    logic        cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
    logic        cpu_done_q, cpu_done_d, dma_done_q, dma_done_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic        wr_err_q, wr_err_d;

    logic        arb_edge, win_any, win_dma;
    logic        sel_we, sel_blk;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    assign arb_edge  = (state_q == IDLE) || (state_q == WAIT);
    assign win_any   = bus_io.cpu_req || bus_io.dma_req;
    assign win_dma   = bus_io.dma_req && ((cnt_q == MaxWait) || !bus_io.cpu_req);
    assign sel_we    = win_dma ? bus_io.dma_we    : bus_io.cpu_we;
    assign sel_addr  = win_dma ? bus_io.dma_addr  : bus_io.cpu_addr;
    assign sel_wdata = win_dma ? bus_io.dma_wdata : bus_io.cpu_wdata;
    assign sel_blk   = RomProtect && sel_we && (sel_addr >= ROM_BASE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        blk_d        = blk_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rw_sel_d = 1'b1;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        cpu_done_d   = 1'b0;
        dma_done_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        wr_err_d     = 1'b0;

        if (state_q == ISSUE) begin
            state_d = WAIT;
        end

        // Completion of the access that is leaving WAIT.
        if (state_q == WAIT) begin
            wr_err_d = blk_q;
            if (owner_q) begin
                dma_done_d = 1'b1;
                if (!we_q) dma_rdata_d = bus_io.mem_rdata;
            end else begin
                cpu_done_d = 1'b1;
                if (!we_q) cpu_rdata_d = bus_io.mem_rdata;
            end
        end

        if (arb_edge) begin
            if (win_any) begin
                state_d      = ISSUE;
                owner_d      = win_dma;
                we_d         = sel_we;
                blk_d        = sel_blk;
                mem_addr_d   = sel_addr;
                mem_wdata_d  = sel_wdata;
                mem_rw_sel_d = ~(sel_we && !sel_blk);
                cpu_gnt_d    = !win_dma;
                dma_gnt_d    = win_dma;
            end else begin
                state_d = IDLE;
            end
            if (bus_io.dma_req) begin
                if (win_dma) begin
                    cnt_d = 4'd0;
                end else if (cnt_q != MaxWait) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge ph2_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            blk_q        <= 1'b0;
            cnt_q        <= 4'd0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 8'h00;
            mem_rw_sel_q <= 1'b1;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            dma_done_q   <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            dma_rdata_q  <= 8'h00;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            blk_q        <= blk_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_sel_q <= mem_rw_sel_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_done_q   <= cpu_done_d;
            dma_done_q   <= dma_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign bus_io.cpu_gnt      = cpu_gnt_q;
    assign bus_io.cpu_done     = cpu_done_q;
    assign bus_io.cpu_rdata    = cpu_rdata_q;
    assign bus_io.dma_gnt      = dma_gnt_q;
    assign bus_io.dma_done     = dma_done_q;
    assign bus_io.dma_rdata    = dma_rdata_q;
    assign bus_io.mem_addr     = mem_addr_q;
    assign bus_io.mem_rw_sel   = mem_rw_sel_q;
    assign bus_io.mem_wdata    = mem_wdata_q;
    assign bus_io.mem_wdata_oe = ~mem_rw_sel_q;
    assign bus_io.wr_err       = wr_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, done-side scoreboard.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam bit RomProt = 1'b1;
`else
    localparam bit RomProt = 1'b0;
`endif

    logic ph2 = 1'b0;
    logic reset = 1'b1;
    always #5 ph2 = ~ph2;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_WAIT(4), .ROM_BASE(16'hC000)) dut (
        .ph2_i   (ph2),
        .reset_i (reset),
        .bus_io  (bus)
    );

    // Synchronous single-port memory sampling on the same edge as the arbiter.
    logic [7:0] mem [0:65535];
    bit mem_init = 1'b0;
    always @(posedge ph2) begin
        if (!mem_init) begin
            mem[16'h0010] <= 8'hA5;
            mem[16'hC000] <= 8'hEE;
            mem[16'hC005] <= 8'h3C;
            mem_init      <= 1'b1;
        end else if (bus.mem_rw_sel) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end else begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int rw_low_cnt = 0;
    int oe_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endfunction

    typedef struct packed {
        logic [7:0] rd;
        logic       werr;
    } sb_t;
    sb_t cpu_q[$];
    sb_t dma_q[$];

    // Scoreboard side: every done pops and checks the oldest outstanding expectation.
    always @(negedge ph2) begin
        sb_t e;
        if (!reset) begin
            if (bus.cpu_done) begin
                if (cpu_q.size() == 0) check("cpu unexpected done", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    check("cpu rdata", bus.cpu_rdata, e.rd);
                    check("cpu wr_err", bus.wr_err, e.werr);
                end
            end
            if (bus.dma_done) begin
                if (dma_q.size() == 0) check("dma unexpected done", 1, 0);
                else begin
                    e = dma_q.pop_front();
                    check("dma rdata", bus.dma_rdata, e.rd);
                    check("dma wr_err", bus.wr_err, e.werr);
                end
            end
            if (!bus.mem_rw_sel) rw_low_cnt++;
            if (bus.mem_wdata_oe !== ~bus.mem_rw_sel) oe_bad++;
        end
    end

    typedef struct {
        bit         dma;
        bit         we;
        logic [15:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
        bit         werr;
        int         low;
    } vec_t;
    vec_t vecs[12];

    logic [46:0] rst_exp = {5'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0};

    function automatic logic [46:0] out_snap();
        return {bus.cpu_gnt, bus.cpu_done, bus.dma_gnt, bus.dma_done, bus.wr_err,
                bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_rw_sel,
                bus.mem_wdata, bus.mem_wdata_oe};
    endfunction

    task automatic drive(input bit dma, input bit req, input bit we,
                         input logic [15:0] a, input logic [7:0] wd);
        if (dma) begin
            bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = wd;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
    endtask

    // Single access from an idle arbiter, with latency and write-strobe checks.
    task automatic access(input string name, input vec_t v);
        int n;
        bit got;
        @(negedge ph2);
        rw_low_cnt = 0;
        drive(v.dma, 1'b1, v.we, v.addr, v.wd);
        if (v.dma) dma_q.push_back('{rd: v.rd, werr: v.werr});
        else cpu_q.push_back('{rd: v.rd, werr: v.werr});
        n = 0; got = 0;
        while (n < 10 && !got) begin
            @(negedge ph2); n++;
            got = v.dma ? bus.dma_gnt : bus.cpu_gnt;
        end
        check({name, " gnt latency"}, n, 1);
        drive(v.dma, 1'b0, v.we, v.addr, v.wd);
        n = 0; got = 0;
        while (n < 10 && !got) begin
            @(negedge ph2); n++;
            got = v.dma ? bus.dma_done : bus.cpu_done;
        end
        check({name, " done latency"}, n, 2);
        check({name, " rw low cycles"}, rw_low_cnt, v.low);
    endtask

    initial begin
        int cg, dg, cyc, dones;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);

        vecs[0]  = '{0, 0, 16'h0010, 8'h00, 8'hA5, 0, 0};
        vecs[1]  = '{0, 1, 16'h0123, 8'h5A, 8'hA5, 0, 1};
        vecs[2]  = '{0, 0, 16'h0123, 8'h00, 8'h5A, 0, 0};
        vecs[3]  = '{1, 0, 16'h0010, 8'h00, 8'hA5, 0, 0};
        vecs[4]  = '{1, 1, 16'h0200, 8'h77, 8'hA5, 0, 1};
        vecs[5]  = '{1, 0, 16'h0200, 8'h00, 8'h77, 0, 0};
        vecs[6]  = '{0, 0, 16'h0200, 8'h00, 8'h77, 0, 0};
        vecs[7]  = '{0, 0, 16'hC005, 8'h00, 8'h3C, 0, 0};
        vecs[8]  = '{0, 1, 16'hC000, 8'h11, 8'h3C, RomProt, RomProt ? 0 : 1};
        vecs[9]  = '{0, 0, 16'hC000, 8'h00, RomProt ? 8'hEE : 8'h11, 0, 0};
        vecs[10] = '{1, 1, 16'h0FFF, 8'hC3, 8'h77, 0, 1};
        vecs[11] = '{0, 0, 16'h0FFF, 8'h00, 8'hC3, 0, 0};

        repeat (2) @(posedge ph2);
        #1 check("reset values", out_snap(), rst_exp);
        @(negedge ph2) reset = 1'b0;

        for (int i = 0; i < 12; i++) access($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests: CPU first, DMA granted in the cycle of cpu_done.
        @(negedge ph2);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 16'h0123, 8'h00);
        cpu_q.push_back('{rd: 8'hA5, werr: 1'b0});
        dma_q.push_back('{rd: 8'h5A, werr: 1'b0});
        @(negedge ph2);
        check("both req cpu gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
        bus.cpu_req = 1'b0;
        @(negedge ph2);
        @(negedge ph2);
        check("cpu done with dma gnt", {bus.cpu_done, bus.dma_gnt}, 2'b11);
        bus.dma_req = 1'b0;
        repeat (4) @(negedge ph2);

        // Starvation: CPU hogs the bus; DMA must win after exactly 4 losses, twice.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 16'h0123, 8'h00);
        cg = 0; dg = 0; cyc = 0;
        while (dg < 2 && cyc < 100) begin
            @(negedge ph2); cyc++;
            if (bus.cpu_gnt) begin
                cpu_q.push_back('{rd: 8'hA5, werr: 1'b0});
                cg++;
            end
            if (bus.dma_gnt) begin
                dma_q.push_back('{rd: 8'h5A, werr: 1'b0});
                check("starve cpu wins before dma", cg, 4);
                cg = 0; dg++;
                if (dg == 2) begin
                    bus.cpu_req = 1'b0;
                    bus.dma_req = 1'b0;
                end
            end
        end
        check("starve dma grants", dg, 2);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (4) @(negedge ph2);

        // Reset during ISSUE of a read: immediate reset values, no done afterwards.
        @(negedge ph2);
        drive(1'b0, 1'b1, 1'b0, 16'h0123, 8'h00);
        @(negedge ph2);
        check("pre-reset cpu gnt", bus.cpu_gnt, 1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1 check("mid-access reset values", out_snap(), rst_exp);
        @(negedge ph2) reset = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge ph2);
            if (bus.cpu_done) dones++;
        end
        check("no done after reset", dones, 0);
        access("post-reset read", vecs[0]);

        repeat (3) @(negedge ph2);
        check("cpu scoreboard drained", cpu_q.size(), 0);
        check("dma scoreboard drained", dma_q.size(), 0);
        check("wdata_oe tracks rw_sel", oe_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
